mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/rv64_mem_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv64_mem_pkg                                                               |
// | Shared types and defaults for the fetch/data memory port arbiter.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rv64_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int TIMEOUT_CYC_DFLT = 64;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb2                                                                    |
// | Two-input round-robin arbiter; the pointer names the side that wins the    |
// | next conflict and only moves when a grant is actually taken.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arb2
    import rv64_mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_if,
    input  logic req_d,
    input  logic advance,
    output logic gnt_if,
    output logic gnt_d
);

    owner_e prio_q;
    owner_e prio_d;

    always_comb begin
        gnt_d  = req_d & (~req_if | (prio_q == OWN_D));
        gnt_if = req_if & ~gnt_d;
        prio_d = prio_q;
        if (advance && gnt_d) begin
            prio_d = OWN_IF;
        end else if (advance && gnt_if) begin
            prio_d = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= OWN_D;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Shares one memory port between fetch and data clients, one transaction     |
// | outstanding, with a read-response timeout.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
    import rv64_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    localparam int              CNT_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             we_q, we_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic w_idle;
    logic w_arb_gnt_if;
    logic w_arb_gnt_d;
    logic w_resp;

    assign w_idle = (state_q == ST_IDLE);
    assign w_resp = (state_q == ST_RESP);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req_if  (if_req),
        .req_d   (d_req),
        .advance (w_idle),
        .gnt_if  (w_arb_gnt_if),
        .gnt_d   (w_arb_gnt_d)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (w_arb_gnt_d) begin
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = ST_ISSUE;
                end else if (w_arb_gnt_if) begin
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    cnt_d = '0;
                    if (we_q) begin
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A response arriving on the final counted cycle still wins over the timeout.
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == C_CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign if_gnt = w_idle & w_arb_gnt_if;
    assign d_gnt  = w_idle & w_arb_gnt_d;

    assign mem_req   = (state_q == ST_ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rvalid = w_resp & (owner_q == OWN_IF);
    assign if_rdata  = if_rvalid ? (addr_q[2] ? rdata_q[63:32] : rdata_q[31:0]) : 32'd0;
    assign if_err    = if_rvalid & err_q;

    assign d_rvalid = w_resp & (owner_q == OWN_D);
    assign d_rdata  = d_rvalid ? rdata_q : 64'd0;
    assign d_err    = d_rvalid & err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                        |
// | Cycle-indexed schedule of stimulus and expected outputs for the arbiter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int MAXC = 512;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [63:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [63:0] d_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // stimulus schedule
    logic        s_rst[MAXC], s_if_req[MAXC], s_d_req[MAXC], s_d_we[MAXC];
    logic [63:0] s_if_addr[MAXC], s_d_addr[MAXC], s_d_wdata[MAXC];
    logic        s_mem_gnt[MAXC], s_mem_rvalid[MAXC];
    logic [63:0] s_mem_rdata[MAXC];
    // expected outputs
    logic        e_if_gnt[MAXC], e_d_gnt[MAXC], e_mem_req[MAXC], e_mem_we[MAXC];
    logic [63:0] e_mem_addr[MAXC], e_mem_wdata[MAXC];
    logic        e_if_rvalid[MAXC], e_if_err[MAXC], e_d_rvalid[MAXC], e_d_err[MAXC];
    logic [31:0] e_if_rdata[MAXC];
    logic [63:0] e_d_rdata[MAXC];

    int checks = 0;
    int failures = 0;
    int t_free, last_g, last_r, last_cyc;
    bit m_prefer_d;
    int glog[$];
    int exp_log[11];
    int t1g, t2g, t4g, t4bg, rst_k;

    task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, act, exp);
        end
    endtask

    // Round-robin rule: on conflict the side not granted last wins; after reset data wins.
    task automatic pick(input bit ireq, input bit dreq, output bit is_d);
        is_d = (ireq && dreq) ? m_prefer_d : dreq;
        m_prefer_d = !is_d;
    endtask

    // Timeline of one transaction granted at the next free IDLE cycle.
    task automatic sched_txn(input bit is_d, input bit we, input logic [63:0] addr,
                             input logic [63:0] wdata, input int req_from, input int gdly,
                             input int rdly, input logic [63:0] rdata);
        int g, gi, r;
        logic [63:0] word;
        logic err;
        g = t_free;
        for (int c = req_from; c <= g; c++) begin
            if (is_d) begin
                s_d_req[c] = 1'b1; s_d_we[c] = we; s_d_addr[c] = addr; s_d_wdata[c] = wdata;
            end else begin
                s_if_req[c] = 1'b1; s_if_addr[c] = addr;
            end
        end
        if (is_d) e_d_gnt[g] = 1'b1; else e_if_gnt[g] = 1'b1;
        gi = g + 1 + gdly;
        for (int c = g + 1; c <= gi; c++) begin
            e_mem_req[c]   = 1'b1;
            e_mem_we[c]    = is_d & we;
            e_mem_addr[c]  = addr;
            e_mem_wdata[c] = is_d ? wdata : 64'd0;
        end
        s_mem_gnt[gi] = 1'b1;
        if (is_d && we) begin
            r = gi + 1; word = 64'd0; err = 1'b0;
        end else if (rdly >= 0 && rdly < TMO) begin
            s_mem_rvalid[gi + 1 + rdly] = 1'b1;
            s_mem_rdata[gi + 1 + rdly]  = rdata;
            r = gi + 2 + rdly; word = rdata; err = 1'b0;
        end else begin
            r = gi + 1 + TMO; word = 64'd0; err = 1'b1;
        end
        if (is_d) begin
            e_d_rvalid[r] = 1'b1; e_d_rdata[r] = word; e_d_err[r] = err;
        end else begin
            e_if_rvalid[r] = 1'b1;
            e_if_rdata[r]  = addr[2] ? word[63:32] : word[31:0];
            e_if_err[r]    = err;
        end
        last_g = g; last_r = r; t_free = r + 1;
    endtask

    task automatic model_reset(input int k);
        for (int c = k + 1; c < MAXC; c++) begin
            e_if_gnt[c] = 0; e_d_gnt[c] = 0; e_mem_req[c] = 0; e_mem_we[c] = 0;
            e_mem_addr[c] = 0; e_mem_wdata[c] = 0; e_if_rvalid[c] = 0; e_if_err[c] = 0;
            e_if_rdata[c] = 0; e_d_rvalid[c] = 0; e_d_err[c] = 0; e_d_rdata[c] = 0;
        end
        s_rst[k] = 1'b1;
        m_prefer_d = 1'b1;
    endtask

    task automatic drive(input int c);
        reset = s_rst[c]; if_req = s_if_req[c]; if_addr = s_if_addr[c];
        d_req = s_d_req[c]; d_we = s_d_we[c]; d_addr = s_d_addr[c]; d_wdata = s_d_wdata[c];
        mem_gnt = s_mem_gnt[c]; mem_rvalid = s_mem_rvalid[c]; mem_rdata = s_mem_rdata[c];
    endtask

    task automatic compare(input int c);
        chk("if_gnt", c, 64'(if_gnt), 64'(e_if_gnt[c]));
        chk("d_gnt", c, 64'(d_gnt), 64'(e_d_gnt[c]));
        chk("gnt_overlap", c, 64'(if_gnt & d_gnt), 64'd0);
        chk("mem_req", c, 64'(mem_req), 64'(e_mem_req[c]));
        if (e_mem_req[c]) begin
            chk("mem_we", c, 64'(mem_we), 64'(e_mem_we[c]));
            chk("mem_addr", c, mem_addr, e_mem_addr[c]);
            chk("mem_wdata", c, mem_wdata, e_mem_wdata[c]);
        end
        chk("if_rvalid", c, 64'(if_rvalid), 64'(e_if_rvalid[c]));
        chk("if_rdata", c, 64'(if_rdata), 64'(e_if_rdata[c]));
        chk("if_err", c, 64'(if_err), 64'(e_if_err[c]));
        chk("d_rvalid", c, 64'(d_rvalid), 64'(e_d_rvalid[c]));
        chk("d_rdata", c, d_rdata, e_d_rdata[c]);
        chk("d_err", c, 64'(d_err), 64'(e_d_err[c]));
    endtask

    initial begin
        bit w;
        int d_from, i_from, dk, ik;
        logic        tdw[2];
        logic [63:0] tda[2], tdd[2], tdr[2], tia[2], tir[2];
        int          tdg[2], tdl[2], tig[2], til[2];

        for (int c = 0; c < MAXC; c++) begin
            s_rst[c] = 0; s_if_req[c] = 0; s_d_req[c] = 0; s_d_we[c] = 0;
            s_if_addr[c] = 0; s_d_addr[c] = 0; s_d_wdata[c] = 0;
            s_mem_gnt[c] = 0; s_mem_rvalid[c] = 0; s_mem_rdata[c] = 0;
        end
        model_reset(0);
        s_rst[1] = 1'b1; s_rst[2] = 1'b1;
        t_free = 4;

        // conflict from reset: four grants alternating D, IF, D, IF
        tdw = '{1'b0, 1'b1}; tda = '{64'h5000, 64'h5008};
        tdd = '{64'h55, 64'hDEAD_BEEF_0000_0001};
        tdr = '{64'h1111_2222_3333_4444, 64'h0}; tdg = '{1, 0}; tdl = '{2, 0};
        tia = '{64'h6004, 64'h6000};
        tir = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        tig = '{0, 2}; til = '{0, 3};
        d_from = t_free; i_from = t_free; dk = 0; ik = 0;
        for (int k = 0; k < 4; k++) begin
            pick(1'b1, 1'b1, w);
            if (w) begin
                sched_txn(1'b1, tdw[dk], tda[dk], tdd[dk], d_from, tdg[dk], tdl[dk], tdr[dk]);
                d_from = last_g + 1; dk++;
            end else begin
                sched_txn(1'b0, 1'b0, tia[ik], 64'd0, i_from, tig[ik], til[ik], tir[ik]);
                i_from = last_g + 1; ik++;
            end
        end

        // fetch with upper-word select
        pick(1'b1, 1'b0, w);
        sched_txn(1'b0, 1'b0, 64'h1004, 64'd0, t_free, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD);
        t1g = last_g;

        // store with delayed mem_gnt
        pick(1'b0, 1'b1, w);
        sched_txn(1'b1, 1'b1, 64'h2000, 64'h1234, t_free, 3, 0, 64'd0);
        t2g = last_g;

        // read timeout, then late responses
        pick(1'b0, 1'b1, w);
        sched_txn(1'b1, 1'b0, 64'h3008, 64'h77, t_free, 0, -1, 64'd0);
        t4g = last_g;
        s_mem_rvalid[last_r + 1] = 1'b1; s_mem_rdata[last_r + 1] = 64'hBAD0_BAD0_BAD0_BAD0;
        s_mem_rvalid[last_r + 2] = 1'b1; s_mem_rdata[last_r + 2] = 64'hBAD1_BAD1_BAD1_BAD1;
        t_free = last_r + 4;

        // response on the very last WAIT cycle before timeout
        pick(1'b1, 1'b0, w);
        sched_txn(1'b0, 1'b0, 64'h4000, 64'd0, t_free, 0, TMO - 1, 64'hCAFE_F00D_1357_9BDF);
        t4bg = last_g;

        // reset while waiting for a read
        pick(1'b0, 1'b1, w);
        sched_txn(1'b1, 1'b0, 64'h7010, 64'h99, t_free, 0, -1, 64'd0);
        rst_k = last_g + 5;
        model_reset(rst_k);
        s_mem_rvalid[rst_k + 2] = 1'b1; s_mem_rdata[rst_k + 2] = 64'hBAD2_BAD2_BAD2_BAD2;
        t_free = rst_k + 3;

        // conflict after reset: data first
        d_from = t_free; i_from = t_free;
        pick(1'b1, 1'b1, w);
        sched_txn(1'b1, 1'b0, 64'h8000, 64'h0, d_from, 0, 1, 64'h0A0B_0C0D_0E0F_1011);
        pick(1'b1, 1'b0, w);
        sched_txn(1'b0, 1'b0, 64'h8004, 64'h0, i_from, 1, 0, 64'h2122_2324_2526_2728);

        last_cyc = t_free + 2;
        exp_log = '{1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0};

        drive(0);
        for (int n = 1; n <= last_cyc; n++) begin
            @(posedge clk);
            #1;
            drive(n);
            @(negedge clk);
            if (n >= 2) begin
                compare(n);
                if (if_gnt) glog.push_back(0);
                if (d_gnt) glog.push_back(1);
                if (n == t1g + 3) begin
                    chk("lit_fetch_rvalid", n, 64'(if_rvalid), 64'd1);
                    chk("lit_fetch_rdata", n, 64'(if_rdata), 64'hAAAA_BBBB);
                end
                if (n == t2g + 2) begin
                    chk("lit_store_addr", n, mem_addr, 64'h2000);
                    chk("lit_store_wdata", n, mem_wdata, 64'h1234);
                end
                if (n == t2g + 5) begin
                    chk("lit_store_ack", n, 64'(d_rvalid), 64'd1);
                    chk("lit_store_rdata", n, d_rdata, 64'd0);
                end
                if (n == t4g + 65) chk("lit_tmo_early", n, 64'(d_rvalid), 64'd0);
                if (n == t4g + 66) begin
                    chk("lit_tmo_rvalid", n, 64'(d_rvalid), 64'd1);
                    chk("lit_tmo_err", n, 64'(d_err), 64'd1);
                    chk("lit_tmo_rdata", n, d_rdata, 64'd0);
                end
                if (n == t4bg + 66) begin
                    chk("lit_last_wait_err", n, 64'(if_err), 64'd0);
                    chk("lit_last_wait_rdata", n, 64'(if_rdata), 64'h1357_9BDF);
                end
                if (n == rst_k + 1) begin
                    chk("lit_rst_mem_req", n, 64'(mem_req), 64'd0);
                    chk("lit_rst_mem_addr", n, mem_addr, 64'd0);
                    chk("lit_rst_mem_wdata", n, mem_wdata, 64'd0);
                end
            end
        end

        chk("grant_log_len", last_cyc, 64'(glog.size()), 64'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < glog.size()) chk("grant_order", i, 64'(glog[i]), 64'(exp_log[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
